fp_compare_pipe: RTL and testbench

//  Parametrised, pipelined IEEE-754 compare/min/max unit for the FPU execute path.

---
 rtl/fp_compare_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_fp_compare_pipe.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: two-stage pipelined IEEE-754 compare / min / max unit.
// Ops: FEQ, FLT, FLE, FMIN, FMAX. Handles +/-0, qNaN and sNaN, and raises an invalid flag.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   flush              kills every in-flight op; a request presented that cycle is dropped
//   in_valid/in_ready  request handshake (in_ready is combinational)
//   op                 000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, others illegal
//   read_data1/2       operands a / b
//   in_tag, out_tag    sideband tag, passed through unchanged
//   out_valid/out_ready result handshake
//   result_out         compare ops: {0..0, bit}; min/max: the selected operand
//   invalid_out        IEEE invalid-operation flag
//   illegal_out        op encoding was illegal; result_out is 0
module fp_compare_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             op,
    input  logic [EXP_W+MAN_W:0]   read_data1,
    input  logic [EXP_W+MAN_W:0]   read_data2,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result_out,
    output logic                   invalid_out,
    output logic                   illegal_out,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int unsigned FLEN  = 1 + EXP_W + MAN_W;
    localparam int unsigned MAG_W = EXP_W + MAN_W;

    localparam logic [2:0] OP_FEQ  = 3'd0;
    localparam logic [2:0] OP_FLT  = 3'd1;
    localparam logic [2:0] OP_FLE  = 3'd2;
    localparam logic [2:0] OP_FMIN = 3'd3;
    localparam logic [2:0] OP_FMAX = 3'd4;

    localparam logic [FLEN-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Operand classification on the raw inputs
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_man, w_b_man;
    logic             w_a_in_nan, w_b_in_nan;

    assign w_a_exp    = read_data1[FLEN-2 -: EXP_W];
    assign w_b_exp    = read_data2[FLEN-2 -: EXP_W];
    assign w_a_man    = read_data1[MAN_W-1:0];
    assign w_b_man    = read_data2[MAN_W-1:0];
    assign w_a_in_nan = (&w_a_exp) && (|w_a_man);
    assign w_b_in_nan = (&w_b_exp) && (|w_b_man);

    // Stage 1 registers
    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;
    logic [FLEN-1:0]  r_s1_a, r_s1_b;
    logic             r_s1_a_zero, r_s1_a_snan, r_s1_a_qnan, r_s1_a_sign;
    logic             r_s1_b_zero, r_s1_b_snan, r_s1_b_qnan, r_s1_b_sign;
    logic             r_s1_mag_lt, r_s1_mag_eq;

    // Stage 2 registers
    logic             r_s2_valid;
    logic [FLEN-1:0]  r_s2_result;
    logic             r_s2_invalid;
    logic             r_s2_illegal;
    logic [TAG_W-1:0] r_s2_tag;

    // Handshake / advance
    logic w_s1_adv, w_s2_adv;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // Ordering decision from the stage-1 class bits
    logic w_a_nan, w_b_nan, w_any_nan, w_any_snan, w_both_zero;
    logic w_eq, w_lt, w_is_min;

    assign w_a_nan     = r_s1_a_snan | r_s1_a_qnan;
    assign w_b_nan     = r_s1_b_snan | r_s1_b_qnan;
    assign w_any_nan   = w_a_nan | w_b_nan;
    assign w_any_snan  = r_s1_a_snan | r_s1_b_snan;
    assign w_both_zero = r_s1_a_zero & r_s1_b_zero;
    assign w_eq        = w_both_zero | ((r_s1_a_sign == r_s1_b_sign) & r_s1_mag_eq);
    assign w_is_min    = (r_s1_op == OP_FMIN);

    // a < b ignoring NaNs; negative values order by descending magnitude
    always_comb begin
        w_lt = 1'b0;
        if (w_both_zero) begin
            w_lt = 1'b0;
        end else if (r_s1_a_sign != r_s1_b_sign) begin
            w_lt = r_s1_a_sign;
        end else if (r_s1_a_sign) begin
            w_lt = !r_s1_mag_lt && !r_s1_mag_eq;
        end else begin
            w_lt = r_s1_mag_lt;
        end
    end

    // Final result and flags
    logic [FLEN-1:0] w_res;
    logic            w_inv, w_ill;

    always_comb begin
        w_res = '0;
        w_inv = 1'b0;
        w_ill = 1'b0;
        case (r_s1_op)
            OP_FEQ: begin
                w_res = FLEN'(!w_any_nan && w_eq);
                w_inv = w_any_snan;
            end
            OP_FLT: begin
                w_res = FLEN'(!w_any_nan && w_lt);
                w_inv = w_any_nan;
            end
            OP_FLE: begin
                w_res = FLEN'(!w_any_nan && (w_lt || w_eq));
                w_inv = w_any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                w_inv = w_any_snan;
                if (w_a_nan && w_b_nan) begin
                    w_res = CANON_NAN;
                end else if (w_a_nan) begin
                    w_res = r_s1_b;
                end else if (w_b_nan) begin
                    w_res = r_s1_a;
                end else if (w_both_zero) begin
                    // min prefers -0, max prefers +0, whichever side it is on
                    if (w_is_min) begin
                        w_res = r_s1_b_sign ? r_s1_b : r_s1_a;
                    end else begin
                        w_res = r_s1_b_sign ? r_s1_a : r_s1_b;
                    end
                end else if (w_is_min) begin
                    w_res = (w_lt || w_eq) ? r_s1_a : r_s1_b;
                end else begin
                    w_res = w_lt ? r_s1_b : r_s1_a;
                end
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    // Pipeline registers; data only moves on an advancing valid slot so stalled outputs hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_op      <= '0;
            r_s1_tag     <= '0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_a_zero  <= 1'b0;
            r_s1_a_snan  <= 1'b0;
            r_s1_a_qnan  <= 1'b0;
            r_s1_a_sign  <= 1'b0;
            r_s1_b_zero  <= 1'b0;
            r_s1_b_snan  <= 1'b0;
            r_s1_b_qnan  <= 1'b0;
            r_s1_b_sign  <= 1'b0;
            r_s1_mag_lt  <= 1'b0;
            r_s1_mag_eq  <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s2_result  <= '0;
            r_s2_invalid <= 1'b0;
            r_s2_illegal <= 1'b0;
            r_s2_tag     <= '0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
            end else begin
                if (w_s1_adv) r_s1_valid <= in_valid;
                if (w_s2_adv) r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv && in_valid) begin
                r_s1_op     <= op;
                r_s1_tag    <= in_tag;
                r_s1_a      <= read_data1;
                r_s1_b      <= read_data2;
                r_s1_a_zero <= ~|read_data1[MAG_W-1:0];
                r_s1_b_zero <= ~|read_data2[MAG_W-1:0];
                r_s1_a_snan <= w_a_in_nan && !w_a_man[MAN_W-1];
                r_s1_a_qnan <= w_a_in_nan &&  w_a_man[MAN_W-1];
                r_s1_b_snan <= w_b_in_nan && !w_b_man[MAN_W-1];
                r_s1_b_qnan <= w_b_in_nan &&  w_b_man[MAN_W-1];
                r_s1_a_sign <= read_data1[FLEN-1];
                r_s1_b_sign <= read_data2[FLEN-1];
                r_s1_mag_lt <= read_data1[MAG_W-1:0] <  read_data2[MAG_W-1:0];
                r_s1_mag_eq <= read_data1[MAG_W-1:0] == read_data2[MAG_W-1:0];
            end
            if (w_s2_adv && r_s1_valid) begin
                r_s2_result  <= w_res;
                r_s2_invalid <= w_inv;
                r_s2_illegal <= w_ill;
                r_s2_tag     <= r_s1_tag;
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign result_out  = r_s2_result;
    assign invalid_out = r_s2_invalid;
    assign illegal_out = r_s2_illegal;
    assign out_tag     = r_s2_tag;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Bench for fp_compare_pipe: single- and double-precision instances sharing control,
// directed vector tables, latency / stall / flush / reset sequences and a randomized
// stream checked against an ordering-key reference model.
module tb_fp_compare_pipe;

    typedef struct packed {
        logic [63:0] res;
        logic        inv;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        inv;
        logic        ill;
    } vec_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  op        = 3'd0;
    logic [4:0]  in_tag    = 5'd0;
    logic [63:0] a_in      = 64'd0;
    logic [63:0] b_in      = 64'd0;
    logic        sel       = 1'b0;

    logic        s_in_ready, s_out_valid, s_inv, s_ill;
    logic [31:0] s_result;
    logic [4:0]  s_tag;
    logic        d_in_ready, d_out_valid, d_inv, d_ill;
    logic [63:0] d_result;
    logic [4:0]  d_tag;

    always #5 clk = ~clk;

    fp_compare_pipe u_s (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .op(op),
        .read_data1(a_in[31:0]), .read_data2(b_in[31:0]), .in_tag(in_tag),
        .out_valid(s_out_valid), .out_ready(out_ready), .result_out(s_result),
        .invalid_out(s_inv), .illegal_out(s_ill), .out_tag(s_tag)
    );

    fp_compare_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) u_d (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d_in_ready), .op(op),
        .read_data1(a_in), .read_data2(b_in), .in_tag(in_tag),
        .out_valid(d_out_valid), .out_ready(out_ready), .result_out(d_result),
        .invalid_out(d_inv), .illegal_out(d_ill), .out_tag(d_tag)
    );

    // Observed outputs of whichever instance is under test
    logic        o_ready, o_valid, o_inv, o_ill;
    logic [63:0] o_res;
    logic [4:0]  o_tag;
    assign o_ready = sel ? d_in_ready  : s_in_ready;
    assign o_valid = sel ? d_out_valid : s_out_valid;
    assign o_res   = sel ? d_result    : {32'h0, s_result};
    assign o_inv   = sel ? d_inv       : s_inv;
    assign o_ill   = sel ? d_ill       : s_ill;
    assign o_tag   = sel ? d_tag       : s_tag;

    int   n_err    = 0;
    int   n_checks = 0;
    exp_t q[$];
    logic stalled_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    // Reference: map each value to a signed ordering key (+0 and -0 both 0)
    function automatic exp_t model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                                   input int ew, input int mw);
        exp_t r;
        longint unsigned mmask, emax, magmask, ma, mb, canon;
        longint ka, kb;
        logic sa, sb, nan_a, nan_b, snan_a, snan_b;
        mmask   = (64'd1 << mw) - 64'd1;
        emax    = (64'd1 << ew) - 64'd1;
        magmask = (64'd1 << (ew + mw)) - 64'd1;
        canon   = (emax << mw) | (64'd1 << (mw - 1));
        ma = a & magmask;
        mb = b & magmask;
        sa = a[ew + mw];
        sb = b[ew + mw];
        nan_a  = ((ma >> mw) == emax) && ((ma & mmask) != 0);
        nan_b  = ((mb >> mw) == emax) && ((mb & mmask) != 0);
        snan_a = nan_a && (((ma >> (mw - 1)) & 64'd1) == 0);
        snan_b = nan_b && (((mb >> (mw - 1)) & 64'd1) == 0);
        ka = sa ? -longint'(ma) : longint'(ma);
        kb = sb ? -longint'(mb) : longint'(mb);
        r = '0;
        case (o)
            3'd0: begin r.res = 64'(!(nan_a || nan_b) && ka == kb); r.inv = snan_a || snan_b; end
            3'd1: begin r.res = 64'(!(nan_a || nan_b) && ka <  kb); r.inv = nan_a || nan_b; end
            3'd2: begin r.res = 64'(!(nan_a || nan_b) && ka <= kb); r.inv = nan_a || nan_b; end
            3'd3, 3'd4: begin
                r.inv = snan_a || snan_b;
                if (nan_a && nan_b)            r.res = canon;
                else if (nan_a)                r.res = b;
                else if (nan_b)                r.res = a;
                else if (ka != kb)             r.res = ((ka < kb) == (o == 3'd3)) ? a : b;
                else if (ma == 0 && mb == 0)   r.res = ((o == 3'd3) == sa) ? a : b;
                else                           r.res = a;
            end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rnd32();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       return {r[31], 31'h0};
            1:       return {r[31], 8'hFF, 23'h0};
            2:       return {r[31], 8'hFF, 1'b1, r[21:0]};
            3:       return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            4:       return {r[31], 8'h00, r[22:0]};
            5:       return {r[31], 8'h3F, r[22:0]};
            default: return r;
        endcase
    endfunction

    function automatic vec_t mk(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] res, input logic inv, input logic ill);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.res = res; v.inv = inv; v.ill = ill;
        return v;
    endfunction

    // One clock: drive at edge+1, sample mid-cycle, score, advance to next edge+1
    task automatic cycle(input logic v, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] t, input logic ordy, input exp_t e,
                         output logic acc, output logic rdy);
        exp_t ex;
        in_valid = v; op = o; a_in = a; b_in = b; in_tag = t; out_ready = ordy;
        #4;
        rdy = o_ready;
        acc = v && rdy && !flush && !rst;
        if (stalled_prev) chk1("hold_valid", o_valid, 1'b1);
        if (o_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output: got result %h tag %0d, none outstanding", o_res, o_tag);
            end else begin
                chk("result", o_res, q[0].res);
                chk("flags_tag", 64'({o_inv, o_ill, o_tag}), 64'({q[0].inv, q[0].ill, q[0].tag}));
                if (ordy) void'(q.pop_front());
            end
        end
        stalled_prev = o_valid && !ordy;
        if (acc) begin
            ex = e;
            ex.tag = t;
            q.push_back(ex);
        end
        @(posedge clk);
        #1;
        if (rst || flush) begin
            q.delete();
            stalled_prev = 1'b0;
        end
    endtask

    task automatic idle(input logic ordy);
        logic acc, rdy;
        cycle(1'b0, 3'd0, 64'd0, 64'd0, 5'd0, ordy, '0, acc, rdy);
    endtask

    task automatic send(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] t, input exp_t e);
        logic acc, rdy;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, o, a, b, t, 1'b1, e, acc, rdy);
            n++;
        end
        if (!acc) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: request tag %0d not accepted, required within 20 cycles", t);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d results missing, required 0", q.size());
            q.delete();
        end
        repeat (3) idle(1'b1);
    endtask

    vec_t tv_s[$];
    vec_t tv_d[$];
    exp_t e;
    logic acc, rdy;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single-precision directed vectors
        tv_s.push_back(mk(3'd1, 64'hBF800000, 64'h3F800000, 64'd1, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd0, 64'h80000000, 64'h00000000, 64'd1, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd1, 64'h80000000, 64'h00000000, 64'd0, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd2, 64'h80000000, 64'h00000000, 64'd1, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd3, 64'h80000000, 64'h00000000, 64'h80000000, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd4, 64'h80000000, 64'h00000000, 64'h00000000, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd3, 64'h00000000, 64'h80000000, 64'h80000000, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd4, 64'h00000000, 64'h80000000, 64'h00000000, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd1, 64'h7FC00000, 64'h3F800000, 64'd0, 1'b1, 1'b0));
        tv_s.push_back(mk(3'd0, 64'h7FC00000, 64'h7FC00000, 64'd0, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd0, 64'h7F800001, 64'h00000000, 64'd0, 1'b1, 1'b0));
        tv_s.push_back(mk(3'd3, 64'h7FC00000, 64'h40000000, 64'h40000000, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd4, 64'h7F800001, 64'hFFC00000, 64'h7FC00000, 1'b1, 1'b0));
        tv_s.push_back(mk(3'd1, 64'hC0000000, 64'hBF800000, 64'd1, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd2, 64'h3F800000, 64'h3F800000, 64'd1, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd1, 64'h3F800000, 64'h3F800000, 64'd0, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd1, 64'h00000001, 64'h00800000, 64'd1, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd3, 64'hFF800000, 64'h7F800000, 64'hFF800000, 1'b0, 1'b0));
        tv_s.push_back(mk(3'd5, 64'h3F800000, 64'h40000000, 64'd0, 1'b0, 1'b1));
        tv_s.push_back(mk(3'd7, 64'h7F800001, 64'h40000000, 64'd0, 1'b0, 1'b1));
        // Double-precision directed vectors
        tv_d.push_back(mk(3'd1, 64'hBFF0000000000000, 64'h3FF0000000000000, 64'd1, 1'b0, 1'b0));
        tv_d.push_back(mk(3'd0, 64'h8000000000000000, 64'h0, 64'd1, 1'b0, 1'b0));
        tv_d.push_back(mk(3'd1, 64'h8000000000000000, 64'h0, 64'd0, 1'b0, 1'b0));
        tv_d.push_back(mk(3'd2, 64'h8000000000000000, 64'h0, 64'd1, 1'b0, 1'b0));
        tv_d.push_back(mk(3'd3, 64'h8000000000000000, 64'h0, 64'h8000000000000000, 1'b0, 1'b0));
        tv_d.push_back(mk(3'd4, 64'h8000000000000000, 64'h0, 64'h0, 1'b0, 1'b0));
        tv_d.push_back(mk(3'd1, 64'h7FF8000000000000, 64'h3FF0000000000000, 64'd0, 1'b1, 1'b0));
        tv_d.push_back(mk(3'd0, 64'h7FF8000000000000, 64'h7FF8000000000000, 64'd0, 1'b0, 1'b0));
        tv_d.push_back(mk(3'd0, 64'h7FF0000000000001, 64'h0, 64'd0, 1'b1, 1'b0));
        tv_d.push_back(mk(3'd3, 64'h7FF8000000000000, 64'h4000000000000000, 64'h4000000000000000, 1'b0, 1'b0));
        tv_d.push_back(mk(3'd4, 64'h7FF0000000000001, 64'hFFF8000000000000, 64'h7FF8000000000000, 1'b1, 1'b0));
        tv_d.push_back(mk(3'd1, 64'hC000000000000000, 64'hBFF0000000000000, 64'd1, 1'b0, 1'b0));
        tv_d.push_back(mk(3'd6, 64'h3FF0000000000000, 64'h0, 64'd0, 1'b0, 1'b1));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("reset_out_valid", o_valid, 1'b0);
        chk("reset_result", o_res, 64'd0);
        chk("reset_flags_tag", 64'({o_inv, o_ill, o_tag}), 64'd0);
        chk1("reset_in_ready", o_ready, 1'b1);

        // T1 latency: accept at cycle 0, result visible at cycle 2
        in_valid = 1'b1; op = 3'd1; a_in = 64'hBF800000; b_in = 64'h3F800000; in_tag = 5'd3; out_ready = 1'b1;
        #4;
        chk1("t1_in_ready", o_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("t1_valid_cycle1", o_valid, 1'b0);
        @(posedge clk); #1;
        chk1("t1_valid_cycle2", o_valid, 1'b1);
        chk("t1_result", o_res, 64'd1);
        chk("t1_flags_tag", 64'({o_inv, o_ill, o_tag}), 64'({1'b0, 1'b0, 5'd3}));
        @(posedge clk); #1;
        chk1("t1_consumed", o_valid, 1'b0);

        // Directed single-precision table
        foreach (tv_s[i]) begin
            e = '{res: tv_s[i].res, inv: tv_s[i].inv, ill: tv_s[i].ill, tag: 5'd0};
            send(tv_s[i].op, tv_s[i].a, tv_s[i].b, 5'(i), e);
        end
        drain();

        // T5: six ops, consumer stalled for the first four cycles
        begin
            int sent, cyc;
            logic [63:0] pa, pb;
            sent = 0;
            cyc = 0;
            pa = {32'h0, rnd32()};
            pb = {32'h0, rnd32()};
            while (sent < 6 && cyc < 40) begin
                e = model(3'(sent % 5), pa, pb, 8, 23);
                cycle(1'b1, 3'(sent % 5), pa, pb, 5'(16 + sent), (cyc >= 4), e, acc, rdy);
                if (cyc < 4) chk1("t5_in_ready", rdy, (cyc < 2));
                if (acc) begin
                    sent++;
                    pa = {32'h0, rnd32()};
                    pb = {32'h0, rnd32()};
                end
                cyc++;
            end
            if (sent < 6) begin
                n_checks++;
                n_err++;
                $display("FAIL t5_accept: accepted %0d ops, required 6", sent);
            end
            drain();
        end

        // Randomized stream with random back-pressure
        begin
            logic        pend;
            logic [2:0]  po;
            logic [63:0] pa, pb;
            logic [4:0]  pt;
            pend = 1'b0; po = 3'd0; pa = 64'd0; pb = 64'd0; pt = 5'd0;
            for (int i = 0; i < 600; i++) begin
                if (!pend) begin
                    pend = ($urandom_range(0, 3) != 0);
                    po   = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                    pa   = {32'h0, rnd32()};
                    case ($urandom_range(0, 3))
                        0:       pb = pa;
                        1:       pb = pa ^ 64'h80000000;
                        default: pb = {32'h0, rnd32()};
                    endcase
                    pt = 5'($urandom);
                end
                e = model(po, pa, pb, 8, 23);
                cycle(pend, po, pa, pb, pt, ($urandom_range(0, 9) < 7), e, acc, rdy);
                if (acc) pend = 1'b0;
            end
            drain();
        end

        // T6a: flush with two ops in flight, then a flush that drops a new request
        cycle(1'b1, 3'd4, 64'h3F800000, 64'h40000000, 5'd9, 1'b0, model(3'd4, 64'h3F800000, 64'h40000000, 8, 23), acc, rdy);
        cycle(1'b1, 3'd3, 64'h3F800000, 64'h40000000, 5'd10, 1'b0, model(3'd3, 64'h3F800000, 64'h40000000, 8, 23), acc, rdy);
        flush = 1'b1;
        idle(1'b0);
        flush = 1'b0;
        chk1("flush_out_valid", o_valid, 1'b0);
        flush = 1'b1;
        cycle(1'b1, 3'd4, 64'h40000000, 64'h3F800000, 5'd11, 1'b1, '0, acc, rdy);
        flush = 1'b0;
        repeat (4) begin
            idle(1'b1);
            chk1("flush_no_stale", o_valid, 1'b0);
        end

        // T6b: reset while stalled with a full pipe
        cycle(1'b1, 3'd4, 64'h3F800000, 64'h40000000, 5'd7, 1'b0, model(3'd4, 64'h3F800000, 64'h40000000, 8, 23), acc, rdy);
        cycle(1'b1, 3'd0, 64'h7F800001, 64'h0, 5'd6, 1'b0, model(3'd0, 64'h7F800001, 64'h0, 8, 23), acc, rdy);
        idle(1'b0);
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
        chk1("rst_out_valid", o_valid, 1'b0);
        chk("rst_result", o_res, 64'd0);
        chk("rst_flags_tag", 64'({o_inv, o_ill, o_tag}), 64'd0);
        chk1("rst_in_ready", o_ready, 1'b1);
        repeat (3) idle(1'b1);

        // Double-precision instance, same directed cases
        sel = 1'b1;
        foreach (tv_d[i]) begin
            e = '{res: tv_d[i].res, inv: tv_d[i].inv, ill: tv_d[i].ill, tag: 5'd0};
            send(tv_d[i].op, tv_d[i].a, tv_d[i].b, 5'(i), e);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
